spi_peripheral: RTL

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_sync2.sv | 34 +++
 rtl/spi_peripheral.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and SPI mode decode helpers for the SPI peripheral.
// Mode encoding: bit1 = CPOL (idle SCK level), bit0 = CPHA.
package spi_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_e;

  function automatic logic spi_cpol(input int mode);
    return mode[1];
  endfunction

  function automatic logic spi_cpha(input int mode);
    return mode[0];
  endfunction

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  function automatic logic spi_sample_on_rise(input int mode);
    return ~(spi_cpol(mode) ^ spi_cpha(mode));
  endfunction

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchronizer bringing an asynchronous SPI pin into the clk domain.
// RESET_VAL presets both stages to the pin's idle level so reset creates no false edge.
module spi_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-state for the two synchronizer stages.
  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
  end

  // Synchronizer stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_sync = sync_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI peripheral (slave) running entirely in the clk domain, MSB first, modes 0-3.
// Define SPI_PERIPH_RX_COUNT_EN to enable the per-frame received-byte counter.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int SPI_MODE         = 3,
  parameter int MAX_BYTES_PER_CS = 2
) (
  input  logic                                  rst,
  input  logic                                  clk,
  input  logic                                  SCK,
  input  logic                                  CS_L,
  input  logic                                  MOSI,
  output logic                                  MISO,
  output logic                                  MISO_OE,
  output logic                                  o_RX_DV,
  output logic [7:0]                            o_RX_Byte,
  output logic [$clog2(MAX_BYTES_PER_CS+1)-1:0] o_RX_Count,
  input  logic [7:0]                            i_TX_Byte,
  input  logic                                  i_TX_DV,
  output logic                                  o_TX_Ready
);

  localparam int   CNT_W       = $clog2(MAX_BYTES_PER_CS + 1);
  localparam logic CPOL        = spi_cpol(SPI_MODE);
  localparam logic CPHA        = spi_cpha(SPI_MODE);
  localparam logic SAMPLE_RISE = spi_sample_on_rise(SPI_MODE);

  logic       sck_s, cs_l_s, mosi_s;
  spi_state_e state_q, state_d;
  logic       sck_d1_q, sck_d1_d, sck_d2_q, sck_d2_d, mosi_d1_q, mosi_d1_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic [7:0] tx_shift_q, tx_shift_d, hold_q, hold_d;
  logic       rx_dv_q, rx_dv_d, miso_q, miso_d, miso_oe_q, miso_oe_d, tx_ready_q, tx_ready_d;
  logic       sample_edge_s, shift_edge_s, byte_start_s, byte_done_s, tx_load_s;
  logic [7:0] next_byte_s;

  spi_sync2 #(.RESET_VAL(CPOL)) u_sync_sck  (.clk(clk), .rst(rst), .i_async(SCK),  .o_sync(sck_s));
  spi_sync2 #(.RESET_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .i_async(CS_L), .o_sync(cs_l_s));
  spi_sync2 #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .i_async(MOSI), .o_sync(mosi_s));

  // Edge detection, byte boundaries and the byte chosen for the next transmission.
  always_comb begin
    if (SAMPLE_RISE) begin
      sample_edge_s = sck_d1_q & ~sck_d2_q;
      shift_edge_s  = ~sck_d1_q & sck_d2_q;
    end else begin
      sample_edge_s = ~sck_d1_q & sck_d2_q;
      shift_edge_s  = sck_d1_q & ~sck_d2_q;
    end
    tx_load_s = i_TX_DV & tx_ready_q;
    // A load arriving on the byte-start cycle wins over the (empty) holding register.
    if (tx_load_s) begin
      next_byte_s = i_TX_Byte;
    end else if (!tx_ready_q) begin
      next_byte_s = hold_q;
    end else begin
      next_byte_s = 8'hFF;
    end
    if (state_q == ST_IDLE) begin
      byte_start_s = ~cs_l_s & ~CPHA;
    end else begin
      byte_start_s = ~cs_l_s & shift_edge_s & (bit_cnt_q == 3'd0);
    end
    byte_done_s = (state_q == ST_SHIFT) & ~cs_l_s & sample_edge_s & (bit_cnt_q == 3'd7);
  end

  // FSM next state and the RX/TX shift datapath.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    sck_d1_d   = sck_s;
    sck_d2_d   = sck_d1_q;
    mosi_d1_d  = mosi_s;
    miso_oe_d  = ~cs_l_s;
    if (byte_start_s) begin
      tx_shift_d = {next_byte_s[6:0], 1'b1};
      miso_d     = next_byte_s[7];
    end else begin
      tx_shift_d = tx_shift_q;
      miso_d     = miso_q;
    end
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d  = 3'd0;
        rx_shift_d = 8'h00;
        if (!cs_l_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_l_s) begin
          state_d    = ST_IDLE;
          bit_cnt_d  = 3'd0;
          rx_shift_d = 8'h00;
          miso_d     = 1'b1;
        end else if (sample_edge_s) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_d1_q};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_byte_d = {rx_shift_q[6:0], mosi_d1_q};
            rx_dv_d   = 1'b1;
          end else begin
            rx_byte_d = rx_byte_q;
          end
        end else if (shift_edge_s && (bit_cnt_q != 3'd0)) begin
          miso_d     = tx_shift_q[7];
          tx_shift_d = {tx_shift_q[6:0], 1'b1};
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // TX holding register: emptied at every byte start, filled by an accepted load.
  always_comb begin
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    if (byte_start_s) begin
      tx_ready_d = 1'b1;
    end else if (tx_load_s) begin
      hold_d     = i_TX_Byte;
      tx_ready_d = 1'b0;
    end else begin
      tx_ready_d = tx_ready_q;
    end
  end

  // Main state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sck_d1_q   <= CPOL;
      sck_d2_q   <= CPOL;
      mosi_d1_q  <= 1'b0;
      bit_cnt_q  <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_dv_q    <= 1'b0;
      tx_shift_q <= 8'hFF;
      hold_q     <= 8'h00;
      miso_q     <= 1'b1;
      miso_oe_q  <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      sck_d1_q   <= sck_d1_d;
      sck_d2_q   <= sck_d2_d;
      mosi_d1_q  <= mosi_d1_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
      tx_shift_q <= tx_shift_d;
      hold_q     <= hold_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      tx_ready_q <= tx_ready_d;
    end
  end

`ifdef SPI_PERIPH_RX_COUNT_EN
  logic [CNT_W-1:0] rx_count_q, rx_count_d;

  // Per-frame received-byte counter, saturating and cleared outside a frame.
  always_comb begin
    if ((state_q == ST_IDLE) || cs_l_s) begin
      rx_count_d = {CNT_W{1'b0}};
    end else if (byte_done_s && (rx_count_q < CNT_W'(MAX_BYTES_PER_CS))) begin
      rx_count_d = rx_count_q + CNT_W'(1);
    end else begin
      rx_count_d = rx_count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count_q <= {CNT_W{1'b0}};
    end else begin
      rx_count_q <= rx_count_d;
    end
  end

  assign o_RX_Count = rx_count_q;
`else
  assign o_RX_Count = {CNT_W{1'b0}};
`endif

  assign MISO       = miso_q;
  assign MISO_OE    = miso_oe_q;
  assign o_RX_DV    = rx_dv_q;
  assign o_RX_Byte  = rx_byte_q;
  assign o_TX_Ready = tx_ready_q;

endmodule
